ws2812_rx: RTL

- Receive-side decoder for the WS2812 single-wire protocol. It recovers 24-bit GRB pixel words from a serial data line by measuring high-pulse widths.
- It reports each pixel with its index, detects the latch (reset) gap, and forwards surplus pixels downstream like a real WS2812 chain element.
- Uses: loopback checking of the existing ws2812 transmitter in the clock display, and chaining a second board.

---
 rtl/ws2812_pkg.sv | 19 +
 rtl/ws2812_rx_if.sv | 15 +
 rtl/ws2812_rx_pulse_meas.sv | 45 ++++
 rtl/ws2812_rx.sv | 116 +++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 receive constants, FSM state type and timing helper.
package ws2812_pkg;
  localparam int BITS_PER_PIXEL = 24;

  // Nominal WS2812 timings: a '0' is ~350 ns high, a '1' is ~800 ns high.
  // The 600 ns decision point sits between them.
  localparam int T0H_NS           = 350;
  localparam int T1H_NS           = 800;
  localparam int T1_THRESH_NS_DEF = 600;
  localparam int TMAX_HIGH_NS_DEF = 2000;
  localparam int TRESET_US_DEF    = 50;

  typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_e;

  // Nanoseconds to whole clock cycles, rounded down.
  function automatic int ns_to_cyc(input int ns, input int mhz);
    return (ns * mhz) / 1000;
  endfunction
endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded pixel / frame event bundle from the WS2812 receiver.
interface ws2812_rx_if #(parameter int NUM_LEDS = 15);
  import ws2812_pkg::*;
  localparam int IDX_W = $clog2(NUM_LEDS + 1);

  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic [IDX_W-1:0]          pixel_index;
  logic                      pixel_valid;
  logic                      frame_done;
  logic [IDX_W-1:0]          frame_pixels;
  logic                      error;

  modport master (output pixel_data, pixel_index, pixel_valid, frame_done, frame_pixels, error);
  modport slave  (input  pixel_data, pixel_index, pixel_valid, frame_done, frame_pixels, error);
endinterface

// File: rtl/ws2812_rx_pulse_meas.sv
// Synchronises din, flags edges and measures run lengths of the current
// level (o_width) and of the run that just ended (o_plen).
module ws2812_rx_pulse_meas #(
  parameter int CW = 10
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          i_din,
  output logic          o_rise,
  output logic          o_fall,
  output logic          o_level,
  output logic [CW-1:0] o_width,
  output logic [CW-1:0] o_plen
);
  logic          r_s1, r_s2, r_d;
  logic [CW-1:0] r_run, r_plen;

  // 2-FF synchroniser, delayed copy for edges, saturating run counter.
  // r_run tracks r_s2: it restarts at 1 on the cycle the new level lands.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_d    <= 1'b0;
      r_run  <= '0;
      r_plen <= '0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      r_d  <= r_s2;
      if (r_s1 != r_s2) begin
        r_run  <= CW'(1);
        r_plen <= r_run;
      end else if (r_run != '1) begin
        r_run <= r_run + CW'(1);
      end
    end
  end

  assign o_rise  = r_s2 & ~r_d;
  assign o_fall  = ~r_s2 & r_d;
  assign o_level = r_s2;
  assign o_width = r_run;
  assign o_plen  = r_plen;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes GRB pixels, detects the latch gap and forwards
// pixels beyond NUM_LEDS on dout like a chained LED.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_MHZ      = 12,
  parameter int NUM_LEDS     = 15,
  parameter int T1_THRESH_NS = T1_THRESH_NS_DEF,
  parameter int TMAX_HIGH_NS = TMAX_HIGH_NS_DEF,
  parameter int TRESET_US    = TRESET_US_DEF
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         din,
  output logic         dout,
  ws2812_rx_if.master  px
);
  localparam int IDX_W      = $clog2(NUM_LEDS + 1);
  localparam int THRESH_CYC = ns_to_cyc(T1_THRESH_NS, CLK_MHZ);
  localparam int MAXH_CYC   = ns_to_cyc(TMAX_HIGH_NS, CLK_MHZ);
  localparam int RESET_CYC  = TRESET_US * CLK_MHZ;
  // One spare code above RESET_CYC so the saturated value never equals it
  // and the latch fires exactly once per gap.
  localparam int CW         = $clog2(RESET_CYC + 2);

  localparam logic [CW-1:0]    THRESH_W = CW'(THRESH_CYC);
  localparam logic [CW-1:0]    MAXH_W   = CW'(MAXH_CYC);
  localparam logic [CW-1:0]    RESET_W  = CW'(RESET_CYC);
  localparam logic [IDX_W-1:0] NUM_W    = IDX_W'(NUM_LEDS);
  localparam logic [4:0]       LAST_BIT = 5'(BITS_PER_PIXEL - 1);

  logic          w_rise, w_fall, w_level, w_fwd, w_bit;
  logic [CW-1:0] w_width, w_plen;

  state_e                    r_state;
  logic [4:0]                r_bit_cnt;
  logic [IDX_W-1:0]          r_pix_cnt;
  logic [BITS_PER_PIXEL-2:0] r_shift;

  ws2812_rx_pulse_meas #(.CW(CW)) u_meas (
    .CLK     (CLK),
    .reset_n (reset_n),
    .i_din   (din),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_level (w_level),
    .o_width (w_width),
    .o_plen  (w_plen)
  );

  assign w_fwd = (r_pix_cnt == NUM_W);
  assign w_bit = (w_plen >= THRESH_W);

  // Decode FSM with registered strobes, counters and forwarded output.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_SYNC;
      r_bit_cnt       <= '0;
      r_pix_cnt       <= '0;
      r_shift         <= '0;
      dout            <= 1'b0;
      px.pixel_data   <= '0;
      px.pixel_index  <= '0;
      px.pixel_valid  <= 1'b0;
      px.frame_done   <= 1'b0;
      px.frame_pixels <= '0;
      px.error        <= 1'b0;
    end else begin
      px.pixel_valid <= 1'b0;
      px.frame_done  <= 1'b0;
      px.error       <= 1'b0;
      // Forwarding switches on at the fall that completes the last local
      // pixel, so the first forwarded pulse is never clipped.
      dout <= (r_state != S_SYNC) && w_fwd && w_level;
      case (r_state)
        S_SYNC: begin
          if (!w_level && w_width >= RESET_W) r_state <= S_LOW;
        end
        S_LOW: begin
          if (w_rise) begin
            r_state <= S_HIGH;
          end else if (w_width == RESET_W) begin
            px.frame_done   <= 1'b1;
            px.frame_pixels <= r_pix_cnt;
            px.error        <= (r_bit_cnt != '0);
            r_bit_cnt       <= '0;
            r_pix_cnt       <= '0;
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            r_state <= S_LOW;
            if (!w_fwd) begin
              if (r_bit_cnt == LAST_BIT) begin
                px.pixel_valid <= 1'b1;
                px.pixel_data  <= {r_shift, w_bit};
                px.pixel_index <= r_pix_cnt;
                r_pix_cnt      <= r_pix_cnt + IDX_W'(1);
                r_bit_cnt      <= '0;
              end else begin
                r_shift   <= {r_shift[BITS_PER_PIXEL-3:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end else if (w_width >= MAXH_W) begin
            px.error  <= 1'b1;
            r_bit_cnt <= '0;
            r_pix_cnt <= '0;
            r_state   <= S_SYNC;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end
endmodule
